ex_mem_skid: RTL and testbench
==============================

// Module: ex_mem_skid
// PURPOSE
//  Registered EX->MEM boundary directly downstream of the ALU. Captures the ALU result and flags
//  (Y, C, V, N, Zero) into a 2-entry skid buffer with valid/ready handshakes on both sides.
//  Resolves conditional branches from the ALU flags and issues a registered one-cycle redirect.
//  Supports a synchronous flush.
// PARAMETERS
//  DATA_W  32  ALU result / branch target width
//  RD_W    5   destination register index width
// PORTS
//  CLK          in   1       clock, rising edge
//  RST          in   1       asynchronous reset, active-high
//  IN_VALID     in   1       upstream (ALU) entry valid
//  IN_READY     out  1       buffer can accept this cycle
//  ALU_Y        in   DATA_W  ALU result
//  ALU_C        in   1       ALU carry; for subtract, 1 = no borrow (A >= B unsigned)
//  ALU_V        in   1       ALU signed overflow
//  ALU_N        in   1       ALU negative
//  ALU_ZERO     in   1       ALU result == 0
//  RD           in   RD_W    destination register
//  IS_BRANCH    in   1       entry is a conditional branch (ALU performed A-B)
//  BR_FUNCT3    in   3       RISC-V branch funct3
//  BR_TARGET    in   DATA_W  branch target address
//  FLUSH        in   1       discard all buffered and incoming entries
//  OUT_VALID    out  1       head entry valid toward MEM
//  OUT_READY    in   1       MEM accepts head entry
//  OUT_Y        out  DATA_W  head result
//  OUT_RD       out  RD_W    head destination
//  OUT_FLAGS    out  4       head {C,V,N,Zero}
//  REDIRECT     out  1       one-cycle pulse: taken branch resolved
//  REDIRECT_PC  out  DATA_W  target for REDIRECT; valid only while REDIRECT = 1
// BEHAVIOUR
//  Reset: all outputs are 0 (IN_READY = 1 after reset deasserts); both entries invalid.
//  Storage: main entry (drives OUT_*) and skid entry, both registered. No combinational
//    path exists from inputs to outputs. IN_READY = !skid_valid and is registered-derived.
//  Accept = IN_VALID & IN_READY. Pop = OUT_VALID & OUT_READY.
//  Latency: an entry accepted in cycle t appears on OUT_* in cycle t+1 when main is empty
//    or popped in cycle t. Otherwise it is stored in skid and moves to main on the next pop.
//  Ordering: strict FIFO. An accept with main full and no pop goes to skid. An accept with
//    skid full is impossible (IN_READY = 0). A pop with skid valid moves skid->main;
//    a same-cycle accept then goes to skid.
//  Simultaneous accept+pop with 1 entry: occupancy stays 1 and the new entry goes to main.
//    Throughput is 1/cycle.
//  Branch condition (evaluated on accept, from ALU flags of A-B):
//    000 BEQ Zero, 001 BNE !Zero, 100 BLT N^V, 101 BGE !(N^V), 110 BLTU !C, 111 BGEU C,
//    010/011 never taken.
//  REDIRECT: registered. If an accepted branch is taken in cycle t, REDIRECT = 1 and
//    REDIRECT_PC = BR_TARGET in cycle t+1 only. REDIRECT is independent of OUT_READY stalls.
//    Branch entries still enter the buffer like any other entry.
//  FLUSH (synchronous, highest priority): at the edge both entries are invalidated, the
//    same-cycle input is dropped (not accepted), and no REDIRECT is generated for it.
//    A REDIRECT already registered from cycle t-1 still fires. IN_READY = 1 the next cycle.
//  Backpressure: OUT_* hold stable while OUT_VALID & !OUT_READY.
//  RST mid-operation: immediately clears entries and REDIRECT; no partial state survives.
// TESTING
//  1 Streaming: IN_VALID=1 with OUT_READY=1, Y=1,2,3,... -> OUT_Y 1,2,3 one cycle later,
//    one per cycle, IN_READY stays 1.
//  2 Stall: OUT_READY=0 while pushing Y=0xA,0xB,0xC -> 0xA, 0xB accepted, IN_READY=0 on
//    the 3rd push. Release OUT_READY -> outputs 0xA, 0xB, 0xC in order, none lost.
//  3 Branches: BEQ Zero=1 -> REDIRECT pulse with PC=BR_TARGET. BLTU C=1 -> no pulse.
//    BLT N=1,V=0 -> pulse. funct3=010 -> no pulse. BGE N=1,V=1 -> pulse.
//  4 Flush: 2 entries buffered + incoming taken branch with FLUSH=1 -> next cycle
//    OUT_VALID=0, IN_READY=1, REDIRECT=0.
//  5 Reset mid-stall: assert RST asynchronously with skid full -> OUT_VALID, REDIRECT,
//    OUT_Y all 0 immediately. After release, IN_READY=1.
//  6 Redirect under stall: OUT_READY=0, accept taken BNE (Zero=0) -> REDIRECT still
//    pulses exactly once in the next cycle.

Source files
------------

// File: rtl/ex_mem_skid_if.sv
// EX->MEM boundary bus: ALU-side handshake and payload, MEM-side handshake
// and payload, flush control and the branch redirect pair.
interface ex_mem_skid_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c;
    logic              alu_v;
    logic              alu_n;
    logic              alu_zero;
    logic [RD_W-1:0]   rd;
    logic              is_branch;
    logic [2:0]        br_funct3;
    logic [DATA_W-1:0] br_target;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_y;
    logic [RD_W-1:0]   out_rd;
    logic [3:0]        out_flags;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;

    // Pipeline-register side
    modport slave (
        input  in_valid, alu_y, alu_c, alu_v, alu_n, alu_zero, rd,
               is_branch, br_funct3, br_target, flush, out_ready,
        output in_ready, out_valid, out_y, out_rd, out_flags,
               redirect, redirect_pc
    );

    // Environment side (ALU producer, MEM consumer, hazard control)
    modport master (
        output in_valid, alu_y, alu_c, alu_v, alu_n, alu_zero, rd,
               is_branch, br_funct3, br_target, flush, out_ready,
        input  in_ready, out_valid, out_y, out_rd, out_flags,
               redirect, redirect_pc
    );
endinterface

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register built as a 2-entry skid buffer (main + skid),
// with branch resolution from the ALU flags of A-B and a registered
// one-cycle redirect pulse. All outputs come straight from flops.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input logic          clk,
    input logic          rst,
    ex_mem_skid_if.slave bus
);
    logic              main_valid_reg;
    logic [DATA_W-1:0] main_y_reg;
    logic [RD_W-1:0]   main_rd_reg;
    logic [3:0]        main_flags_reg;
    logic              skid_valid_reg;
    logic [DATA_W-1:0] skid_y_reg;
    logic [RD_W-1:0]   skid_rd_reg;
    logic [3:0]        skid_flags_reg;
    logic              redirect_reg;
    logic [DATA_W-1:0] redirect_pc_reg;

    logic       accept;
    logic       pop;
    logic       taken;
    logic [3:0] in_flags;

    // Flush drops the incoming entry, so it never counts as accepted.
    assign accept   = bus.in_valid & ~skid_valid_reg & ~bus.flush;
    assign pop      = main_valid_reg & bus.out_ready;
    assign in_flags = {bus.alu_c, bus.alu_v, bus.alu_n, bus.alu_zero};

    // Branch condition from the flags of A-B; C = 1 means no borrow.
    always_comb begin
        taken = 1'b0;
        if (bus.is_branch) begin
            case (bus.br_funct3)
                3'b000:  taken = bus.alu_zero;
                3'b001:  taken = ~bus.alu_zero;
                3'b100:  taken = bus.alu_n ^ bus.alu_v;
                3'b101:  taken = ~(bus.alu_n ^ bus.alu_v);
                3'b110:  taken = ~bus.alu_c;
                3'b111:  taken = bus.alu_c;
                default: taken = 1'b0;
            endcase
        end
    end

    // Main/skid storage: FIFO order, skid only fills when main is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_y_reg     <= '0;
            main_rd_reg    <= '0;
            main_flags_reg <= '0;
            skid_valid_reg <= 1'b0;
            skid_y_reg     <= '0;
            skid_rd_reg    <= '0;
            skid_flags_reg <= '0;
        end else if (bus.flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            // No accept possible here (in_ready is low); a pop promotes skid.
            if (pop) begin
                main_y_reg     <= skid_y_reg;
                main_rd_reg    <= skid_rd_reg;
                main_flags_reg <= skid_flags_reg;
                skid_valid_reg <= 1'b0;
            end
        end else if (main_valid_reg && !pop) begin
            // Main is held this cycle: a new entry parks in skid.
            if (accept) begin
                skid_valid_reg <= 1'b1;
                skid_y_reg     <= bus.alu_y;
                skid_rd_reg    <= bus.rd;
                skid_flags_reg <= in_flags;
            end
        end else begin
            // Main is empty or draining: a new entry goes straight to main.
            main_valid_reg <= accept;
            if (accept) begin
                main_y_reg     <= bus.alu_y;
                main_rd_reg    <= bus.rd;
                main_flags_reg <= in_flags;
            end
        end
    end

    // Redirect pulse: one cycle after a taken branch is accepted, regardless
    // of where that branch entry sits in the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            redirect_reg    <= accept & taken;
            redirect_pc_reg <= (accept && taken) ? bus.br_target : '0;
        end
    end

    assign bus.in_ready    = ~skid_valid_reg;
    assign bus.out_valid   = main_valid_reg;
    assign bus.out_y       = main_y_reg;
    assign bus.out_rd      = main_rd_reg;
    assign bus.out_flags   = main_flags_reg;
    assign bus.redirect    = redirect_reg;
    assign bus.redirect_pc = redirect_pc_reg;
endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: a negedge monitor keeps a queue of expected entries
// (pushed on accept, compared at the head, popped on handshake) and an
// expected redirect for the following cycle.
module tb_ex_mem_skid;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_mem_skid_if #(.DATA_W(32), .RD_W(5)) bus ();

    ex_mem_skid #(.DATA_W(32), .RD_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] y;
        logic [4:0]  rd;
        logic [3:0]  flags;
    } entry_t;

    entry_t      exp_q[$];
    logic        exp_redir = 1'b0;
    logic [31:0] exp_pc    = '0;
    int          n_cmp     = 0;
    int          n_err     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reading of the branch table; fl = {C,V,N,Zero}.
    function automatic logic br_taken(input logic br, input logic [2:0] f3, input logic [3:0] fl);
        logic c, v, n, z;
        c = fl[3]; v = fl[2]; n = fl[1]; z = fl[0];
        if (!br) return 1'b0;
        case (f3)
            3'b000: return z;
            3'b001: return !z;
            3'b100: return n != v;
            3'b101: return n == v;
            3'b110: return !c;
            3'b111: return c;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_redir = 1'b0;
            exp_pc    = '0;
        end else begin
            logic   acc, pop, nx_redir;
            entry_t e;
            check("redirect", bus.redirect, exp_redir);
            if (exp_redir) check("redirect_pc", bus.redirect_pc, exp_pc);
            check("in_ready", bus.in_ready, exp_q.size() < 2);
            check("out_valid", bus.out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("out_y", bus.out_y, exp_q[0].y);
                check("out_rd", bus.out_rd, exp_q[0].rd);
                check("out_flags", bus.out_flags, exp_q[0].flags);
            end
            pop = (exp_q.size() > 0) && bus.out_ready;
            acc = bus.in_valid && (exp_q.size() < 2) && !bus.flush;
            e.y     = bus.alu_y;
            e.rd    = bus.rd;
            e.flags = {bus.alu_c, bus.alu_v, bus.alu_n, bus.alu_zero};
            nx_redir = acc && br_taken(bus.is_branch, bus.br_funct3, e.flags);
            exp_redir = nx_redir;
            exp_pc    = bus.br_target;
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] y, input logic [4:0] rd, input logic [3:0] fl,
                         input logic br, input logic [2:0] f3, input logic [31:0] tgt);
        bus.in_valid  = 1'b1;
        bus.alu_y     = y;
        bus.rd        = rd;
        {bus.alu_c, bus.alu_v, bus.alu_n, bus.alu_zero} = fl;
        bus.is_branch = br;
        bus.br_funct3 = f3;
        bus.br_target = tgt;
    endtask

    // Hold one entry on the input until it is taken (bounded).
    task automatic send(input logic [31:0] y, input logic [4:0] rd, input logic [3:0] fl,
                        input logic br, input logic [2:0] f3, input logic [31:0] tgt);
        logic ok;
        ok = 1'b0;
        drive(y, rd, fl, br, f3, tgt);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready && !bus.flush;
            cyc();
        end
        check("send_accepted", ok, 1'b1);
    endtask

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus.is_branch = 1'b0;
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.alu_y = 0; bus.alu_c = 0; bus.alu_v = 0; bus.alu_n = 0;
        bus.alu_zero = 0; bus.rd = 0; bus.is_branch = 0; bus.br_funct3 = 0;
        bus.br_target = 0; bus.flush = 0; bus.out_ready = 0;
        repeat (3) cyc();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_redirect", bus.redirect, 0);
        check("rst_out_y", bus.out_y, 0);
        rst = 1'b0;
        cyc();
        check("post_rst_in_ready", bus.in_ready, 1);

        // Streaming at full rate
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(i, 5'(i), 4'(i), 1'b0, 3'b000, 0);
        idle(3);
        $display("stream: 8 entries done");

        // Stall: A, B accepted, C blocked until release
        bus.out_ready = 1'b0;
        send(32'hA, 5'd10, 4'h1, 1'b0, 3'b000, 0);
        send(32'hB, 5'd11, 4'h2, 1'b0, 3'b000, 0);
        drive(32'hC, 5'd12, 4'h3, 1'b0, 3'b000, 0);
        cyc(); cyc();
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_head", bus.out_y, 32'hA);
        bus.out_ready = 1'b1;
        send(32'hC, 5'd12, 4'h3, 1'b0, 3'b000, 0);
        idle(4);
        $display("stall: A B C drained");

        // Branches (flags = {C,V,N,Z})
        send(32'h0, 5'd1, 4'b0001, 1'b1, 3'b000, 32'h1000);  // BEQ Z=1   taken
        send(32'h1, 5'd2, 4'b1000, 1'b1, 3'b110, 32'h2000);  // BLTU C=1  not
        send(32'h2, 5'd3, 4'b0010, 1'b1, 3'b100, 32'h3000);  // BLT N^V   taken
        send(32'h3, 5'd4, 4'b0001, 1'b1, 3'b010, 32'h4000);  // 010       not
        send(32'h4, 5'd5, 4'b0110, 1'b1, 3'b101, 32'h5000);  // BGE N=V   taken
        send(32'h5, 5'd6, 4'b0000, 1'b1, 3'b111, 32'h6000);  // BGEU C=0  not
        idle(3);
        $display("branches: 6 resolved");

        // Flush with two buffered entries and an incoming taken branch
        bus.out_ready = 1'b0;
        send(32'h11, 5'd1, 4'h0, 1'b0, 3'b000, 0);
        send(32'h22, 5'd2, 4'h0, 1'b0, 3'b000, 0);
        drive(32'h0, 5'd3, 4'b0001, 1'b1, 3'b000, 32'h7000);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush2_out_valid", bus.out_valid, 0);
        check("flush2_in_ready", bus.in_ready, 1);
        check("flush2_redirect", bus.redirect, 0);
        idle(2);

        // Flush right after a taken branch: old pulse fires, new one dropped
        send(32'h33, 5'd4, 4'b0001, 1'b1, 3'b000, 32'h8000);
        check("pre_flush_redirect", bus.redirect, 1);
        drive(32'h0, 5'd5, 4'b0001, 1'b1, 3'b000, 32'h9000);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush1_redirect", bus.redirect, 0);
        check("flush1_out_valid", bus.out_valid, 0);
        idle(2);
        $display("flush: two cases done");

        // Asynchronous reset with skid full and a redirect pending
        send(32'h44, 5'd6, 4'h0, 1'b0, 3'b000, 0);
        send(32'h55, 5'd7, 4'b0001, 1'b1, 3'b000, 32'hA000);
        check("pre_rst_redirect", bus.redirect, 1);
        check("pre_rst_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_redirect", bus.redirect, 0);
        check("arst_out_y", bus.out_y, 0);
        cyc();
        rst = 1'b0;
        check("arst_in_ready", bus.in_ready, 1);
        idle(2);
        $display("reset: mid-stall reset done");

        // Redirect while MEM is stalled: exactly one pulse
        send(32'h66, 5'd8, 4'b0000, 1'b1, 3'b001, 32'hB000);
        check("stall_redirect", bus.redirect, 1);
        check("stall_redirect_pc", bus.redirect_pc, 32'hB000);
        idle(1);
        check("stall_redirect_gone", bus.redirect, 0);
        idle(3);
        bus.out_ready = 1'b1;
        idle(3);
        $display("redirect under stall done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
